simple_mem_responder: RTL and testbench

- Synthesizable BRAM-backed memory endpoint on the responder side of the Simplified Memory interface (MemReq/MemResp with grants).
- Role logic, or the DRAM interleaver's channel outputs, connect to it in place of a real DRAM controller.
- Used for simulation and on-chip loopback tests when DRAM is unavailable.
- Writes complete silently. Reads return 512-bit lines in request order after a fixed pipeline latency, with credit-based backpressure.

---
 rtl/simple_mem_responder_pkg.sv | 36 +++
 rtl/simple_mem_fifo.sv | 40 ++++
 rtl/simple_mem_read_pipe.sv | 51 +++++
 rtl/simple_mem_responder.sv | 130 +++++++++++++
 tb/tb_simple_mem_responder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/simple_mem_responder_pkg.sv
// Shared types for the simple memory responder: line geometry, the MemReq/MemResp
// channel structs and the request-decode enum used by the top level.
package simple_mem_responder_pkg;

    localparam int MEM_LINE_BYTES       = 64;
    localparam int MEM_LINE_OFFSET_BITS = 6;
    localparam int MEM_DATA_BITS        = 512;
    localparam int MEM_ADDR_BITS        = 64;

    typedef struct packed {
        logic                     valid;
        logic                     isWrite;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [MEM_DATA_BITS-1:0] data;
    } MemReq;

    typedef struct packed {
        logic                     valid;
        logic [MEM_DATA_BITS-1:0] data;
    } MemResp;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_WRITE,
        REQ_READ,
        REQ_STALL
    } req_kind_e;

    // True when the address is line aligned and lies inside the stored range.
    function automatic logic line_addr_ok(input logic [MEM_ADDR_BITS-1:0] addr,
                                          input int log_depth);
        return (addr[MEM_LINE_OFFSET_BITS-1:0] == '0) &&
               ((addr >> (log_depth + MEM_LINE_OFFSET_BITS)) == '0);
    endfunction

endpackage

// File: rtl/simple_mem_fifo.sv
// Show-ahead FIFO: the head entry is visible on 'head' whenever 'empty' is low.
// Writing while full is not guarded; callers bound occupancy themselves.
module simple_mem_fifo #(
    parameter int WIDTH     = 512,
    parameter int LOG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam logic [LOG_DEPTH:0] PTR_ONE = (LOG_DEPTH+1)'(1);

    logic [WIDTH-1:0] storage [2**LOG_DEPTH];
    logic [LOG_DEPTH:0] wr_ptr;
    logic [LOG_DEPTH:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage has no reset so it can map onto distributed or block RAM.
    always_ff @(posedge clk) begin
        if (push) storage[wr_ptr[LOG_DEPTH-1:0]] <= push_data;
    end

    assign head  = storage[rd_ptr[LOG_DEPTH-1:0]];
    assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/simple_mem_read_pipe.sv
// Line storage plus the read delay line: a registered array read followed by
// READ_LATENCY-1 valid/data stages, producing one valid/data pair per granted read.
module simple_mem_read_pipe
    import simple_mem_responder_pkg::*;
#(
    parameter int LOG_DEPTH    = 14,
    parameter int READ_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [LOG_DEPTH-1:0]     wr_index,
    input  logic [MEM_DATA_BITS-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [LOG_DEPTH-1:0]     rd_index,
    output logic                     out_valid,
    output logic [MEM_DATA_BITS-1:0] out_data
);

    logic [MEM_DATA_BITS-1:0] mem [2**LOG_DEPTH];
    logic [READ_LATENCY-1:0]  stage_valid;
    logic [MEM_DATA_BITS-1:0] stage_data [READ_LATENCY];

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_index] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en) stage_data[0] <= mem[rd_index];
        for (int i = 1; i < READ_LATENCY; i++) begin
            stage_data[i] <= stage_data[i-1];
        end
    end

    // Only the valid bits are cleared, which is what discards in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= rd_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    assign out_valid = stage_valid[READ_LATENCY-1];
    assign out_data  = stage_data[READ_LATENCY-1];

endmodule

// File: rtl/simple_mem_responder.sv
// BRAM-backed responder for the MemReq/MemResp interface with credit-limited reads.
// Define SIMPLE_MEM_ADDR_CHECK_EN to build the sticky misaligned/out-of-range 'err' flag.
module simple_mem_responder
    import simple_mem_responder_pkg::*;
#(
    parameter int LOG_DEPTH    = 14,
    parameter int READ_LATENCY = 4,
    parameter int LOG_RESP_Q   = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  MemReq  mem_req,
    output logic   mem_req_grant,
    output MemResp mem_resp,
    input  logic   mem_resp_grant,
    output logic   err
);

    localparam int                  RESP_Q_DEPTH = 2**LOG_RESP_Q;
    localparam logic [LOG_RESP_Q:0] CREDIT_MAX   = (LOG_RESP_Q+1)'(RESP_Q_DEPTH);
    localparam logic [LOG_RESP_Q:0] CREDIT_ONE   = (LOG_RESP_Q+1)'(1);

    req_kind_e                req_kind;
    logic [LOG_RESP_Q:0]      credit_cnt;
    logic                     write_grant;
    logic                     read_grant;
    logic [LOG_DEPTH-1:0]     line_index;

    logic                     pipe_valid;
    logic [MEM_DATA_BITS-1:0] pipe_data;
    logic                     fifo_empty;
    logic [MEM_DATA_BITS-1:0] fifo_head;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     resp_valid;
    logic [MEM_DATA_BITS-1:0] resp_data;
    logic                     resp_fire;

    // Grant depends only on the request and registered credit, never on mem_resp_grant.
    always_comb begin
        req_kind = REQ_IDLE;
        if (!rst && mem_req.valid) begin
            if (mem_req.isWrite)               req_kind = REQ_WRITE;
            else if (credit_cnt < CREDIT_MAX)  req_kind = REQ_READ;
            else                               req_kind = REQ_STALL;
        end
    end

    assign write_grant   = (req_kind == REQ_WRITE);
    assign read_grant    = (req_kind == REQ_READ);
    assign mem_req_grant = write_grant || read_grant;
    assign line_index    = mem_req.addr[LOG_DEPTH+MEM_LINE_OFFSET_BITS-1:MEM_LINE_OFFSET_BITS];

    simple_mem_read_pipe #(
        .LOG_DEPTH    (LOG_DEPTH),
        .READ_LATENCY (READ_LATENCY)
    ) read_pipe (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (write_grant),
        .wr_index  (line_index),
        .wr_data   (mem_req.data),
        .rd_en     (read_grant),
        .rd_index  (line_index),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    // An arriving line bypasses an empty queue so first-read latency stays READ_LATENCY.
    always_comb begin
        resp_valid = !rst && (!fifo_empty || pipe_valid);
        resp_data  = fifo_empty ? pipe_data : fifo_head;
        resp_fire  = resp_valid && mem_resp_grant;
        fifo_push  = !rst && pipe_valid && !(fifo_empty && mem_resp_grant);
        fifo_pop   = resp_fire && !fifo_empty;
    end

    simple_mem_fifo #(
        .WIDTH     (MEM_DATA_BITS),
        .LOG_DEPTH (LOG_RESP_Q)
    ) resp_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (pipe_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty)
    );

    always_comb begin
        mem_resp       = '0;
        mem_resp.valid = resp_valid;
        mem_resp.data  = resp_valid ? resp_data : '0;
    end

    // Credits cover reads in the delay line plus reads parked in the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= '0;
        end else begin
            case ({read_grant, resp_fire})
                2'b10:   credit_cnt <= credit_cnt + CREDIT_ONE;
                2'b01:   credit_cnt <= credit_cnt - CREDIT_ONE;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

`ifdef SIMPLE_MEM_ADDR_CHECK_EN
    logic err_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag <= 1'b0;
        end else if (mem_req_grant && !line_addr_ok(mem_req.addr, LOG_DEPTH)) begin
            err_flag <= 1'b1;
        end
    end

    assign err = err_flag;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^{mem_req.addr[MEM_ADDR_BITS-1:LOG_DEPTH+MEM_LINE_OFFSET_BITS],
                                mem_req.addr[MEM_LINE_OFFSET_BITS-1:0]};
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_simple_mem_responder.sv
// Directed and randomized bench for simple_mem_responder, checked against a
// queue-and-array reference model of the responder's external behaviour.
module tb_simple_mem_responder;
    import simple_mem_responder_pkg::*;

    localparam int LOG_DEPTH  = 14;
    localparam int RL         = 4;
    localparam int LOG_RESP_Q = 4;
    localparam int Q_DEPTH    = 2**LOG_RESP_Q;
    localparam int NUM_LINES  = 2**LOG_DEPTH;

    logic   clk = 1'b0;
    logic   rst;
    MemReq  mem_req;
    logic   mem_req_grant;
    MemResp mem_resp;
    logic   mem_resp_grant;
    logic   err;

    simple_mem_responder #(
        .LOG_DEPTH    (LOG_DEPTH),
        .READ_LATENCY (RL),
        .LOG_RESP_Q   (LOG_RESP_Q)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_req_grant  (mem_req_grant),
        .mem_resp       (mem_resp),
        .mem_resp_grant (mem_resp_grant),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           ready;
        bit           known;
        logic [511:0] data;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    int           cycle  = 0;
    exp_t         exp_q[$];
    logic [511:0] model_mem [int];
    bit           err_model = 1'b0;

    function automatic int line_of(input logic [63:0] addr);
        return int'((addr / 64) % NUM_LINES);
    endfunction

    function automatic bit addr_bad(input logic [63:0] addr);
        return ((addr % 64) != 0) || ((addr / (64 * NUM_LINES)) != 0);
    endfunction

    function automatic logic [511:0] pattern(input logic [31:0] seed);
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = seed ^ (32'h0101_0101 * i);
        return p;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic applyStimulus(input bit r, input bit v, input bit w,
                                 input logic [63:0] a, input logic [511:0] d,
                                 input bit g);
        rst             = r;
        mem_req.valid   = v;
        mem_req.isWrite = w;
        mem_req.addr    = a;
        mem_req.data    = d;
        mem_resp_grant  = g;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h",
                   tag, cycle, observed, expected);
        end
    endtask

    // Check outputs mid-cycle, then advance the reference model across the edge.
    task automatic tick();
        bit           exp_grant;
        bit           exp_valid;
        bit           s_rst, s_write, s_rgrant;
        logic [63:0]  s_addr;
        logic [511:0] s_data;
        exp_t         e;
        #1;
        exp_grant = !rst && mem_req.valid && (mem_req.isWrite || exp_q.size() < Q_DEPTH);
        exp_valid = !rst && exp_q.size() > 0 && exp_q[0].ready <= cycle;
        checkOutput("req_grant", 512'(mem_req_grant), 512'(exp_grant));
        checkOutput("resp_valid", 512'(mem_resp.valid), 512'(exp_valid));
        if (!exp_valid)
            checkOutput("resp_data_idle", mem_resp.data, '0);
        else if (exp_q[0].known)
            checkOutput("resp_data", mem_resp.data, exp_q[0].data);
        checkOutput("err", 512'(err), 512'(err_model));
        s_rst    = rst;
        s_write  = mem_req.isWrite;
        s_addr   = mem_req.addr;
        s_data   = mem_req.data;
        s_rgrant = mem_resp_grant;
        @(posedge clk);
        if (s_rst) begin
            exp_q.delete();
            err_model = 1'b0;
        end else begin
            if (exp_valid && s_rgrant) void'(exp_q.pop_front());
            if (exp_grant) begin
`ifdef SIMPLE_MEM_ADDR_CHECK_EN
                if (addr_bad(s_addr)) err_model = 1'b1;
`endif
                if (s_write) begin
                    model_mem[line_of(s_addr)] = s_data;
                end else begin
                    e.ready = cycle + RL;
                    e.known = model_mem.exists(line_of(s_addr));
                    e.data  = e.known ? model_mem[line_of(s_addr)] : '0;
                    exp_q.push_back(e);
                end
            end
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic doReq(input bit w, input logic [63:0] a, input logic [511:0] d,
                         input bit g);
        applyStimulus(1'b0, 1'b1, w, a, d, g);
        tick();
    endtask

    task automatic idle(input int n, input bit g);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, '0, g);
            tick();
        end
    endtask

    initial begin
        logic [511:0] line_a, line_b, line_c, line_d;
        logic [63:0]  addr;
        line_a = pattern(32'hAAAA_0001);
        line_b = pattern(32'hBBBB_0002);
        line_c = pattern(32'hCCCC_0003);
        line_d = pattern(32'hDDDD_0004);

        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, '0, 1'b1);
        tick();

        $display("[TB] in-order reads");
        doReq(1'b1, 64'h00, line_a, 1'b1);
        doReq(1'b1, 64'h40, line_b, 1'b1);
        doReq(1'b0, 64'h40, '0, 1'b1);
        doReq(1'b0, 64'h00, '0, 1'b1);
        idle(RL + 3, 1'b1);

        $display("[TB] read-after-write");
        doReq(1'b1, 64'h80, line_a, 1'b1);
        doReq(1'b0, 64'h80, '0, 1'b1);
        doReq(1'b1, 64'h80, line_c, 1'b1);
        doReq(1'b0, 64'h80, '0, 1'b1);
        idle(RL + 3, 1'b1);

        for (int i = 4; i < 36; i++) doReq(1'b1, 64'(i * 64), rand_line(), 1'b1);

        $display("[TB] backpressure");
        for (int i = 0; i < 20; i++) doReq(1'b0, 64'((i + 4) * 64), '0, 1'b0);
        idle(3, 1'b0);
        for (int i = 16; i < 20; i++) doReq(1'b0, 64'((i + 4) * 64), '0, 1'b1);
        idle(30, 1'b1);

        $display("[TB] credit boundary");
        for (int i = 0; i < 15; i++) doReq(1'b0, 64'((i + 4) * 64), '0, 1'b0);
        idle(RL + 1, 1'b0);
        doReq(1'b0, 64'(30 * 64), '0, 1'b1);
        doReq(1'b0, 64'(31 * 64), '0, 1'b0);
        doReq(1'b0, 64'(32 * 64), '0, 1'b0);
        idle(2, 1'b0);
        idle(25, 1'b1);

        $display("[TB] aliasing");
        doReq(1'b1, 64'h10_0000, line_d, 1'b1);
        doReq(1'b0, 64'h0, '0, 1'b1);
        idle(RL + 4, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 6; i++) doReq(1'b0, 64'((i + 4) * 64), '0, 1'b0);
        idle(1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h40, '0, 1'b1);
        tick();
        idle(RL + 2, 1'b1);
        for (int i = 0; i < 16; i++) doReq(1'b0, 64'((i + 4) * 64), '0, 1'b0);
        idle(RL + 2, 1'b0);
        idle(25, 1'b1);
        doReq(1'b0, 64'h40, '0, 1'b1);
        doReq(1'b0, 64'h80, '0, 1'b1);
        idle(RL + 2, 1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) begin
            addr = 64'($urandom_range(0, 11) * 64);
            if ($urandom_range(0, 15) == 0) addr = addr | 64'($urandom_range(1, 63));
            if ($urandom_range(0, 15) == 0) addr = addr | (64'd1 << $urandom_range(20, 63));
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 2) == 0, addr, rand_line(),
                          $urandom_range(0, 3) != 0);
            tick();
        end
        idle(40, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
